// File: rtl/soc_system_sw_debounce.sv
// Per-bit switch debouncer: 2-flop synchronizer, then a saturating stability
// counter that commits the synchronized level once it has held long enough.
module soc_system_sw_debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_WIDTH       = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_in,
  output logic sw_out,
  output logic sw_changed,
  output logic update
);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 s1, s2;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 mismatch;

  assign mismatch = (s2 != sw_out);
  assign update   = mismatch && (cnt == CNT_MAX);

  // A counter reaching CNT_MAX always commits and clears, so it can never wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      cnt        <= '0;
      sw_out     <= 1'b0;
      sw_changed <= 1'b0;
    end else begin
      s1         <= sw_in;
      s2         <= s1;
      sw_changed <= update;
      if (!mismatch) begin
        cnt <= '0;
      end else if (update) begin
        cnt    <= '0;
        sw_out <= s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module soc_system_sw_debounce #(
  parameter int WIDTH           = 10,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_WIDTH       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_out,
  output logic [WIDTH-1:0] sw_changed,
  output logic             any_change
);
  logic [WIDTH-1:0] update;

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    soc_system_sw_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_WIDTH      (CNT_WIDTH)
    ) u_bit (
      .clk       (clk),
      .reset     (reset),
      .sw_in     (sw_in[b]),
      .sw_out    (sw_out[b]),
      .sw_changed(sw_changed[b]),
      .update    (update[b])
    );
  end

  // Registered from the same update terms so it lines up with sw_changed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) any_change <= 1'b0;
    else       any_change <= |update;
  end
endmodule
